// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage and its decoder: instruction-type
// encodings, IR field bit positions, fetch FSM states and the reset PC.
package cpu_pkg;

  typedef enum logic [1:0] {
    TYPE_R    = 2'b00,
    TYPE_I    = 2'b01,
    TYPE_J    = 2'b10,
    TYPE_RSVD = 2'b11
  } inst_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_TRAP
  } fetch_state_e;

  localparam int unsigned RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int FUNC_MSB  = 31;
  localparam int FUNC_LSB  = 27;
  localparam int RS1_MSB   = 26;
  localparam int RS1_LSB   = 22;
  localparam int RD_MSB    = 21;
  localparam int RD_LSB    = 17;
  localparam int RS2_MSB   = 16;
  localparam int RS2_LSB   = 12;
  localparam int TYPE_MSB  = 2;
  localparam int TYPE_LSB  = 1;
  localparam int STOP_BIT  = 0;
  localparam int IMM_I_MSB = 16;
  localparam int IMM_I_LSB = 3;
  localparam int IMM_J_MSB = 26;
  localparam int IMM_J_LSB = 3;
  localparam int IMM_I_W   = IMM_I_MSB - IMM_I_LSB + 1;
  localparam int IMM_J_W   = IMM_J_MSB - IMM_J_LSB + 1;

endpackage

// File: rtl/inst_decoder.sv
// Combinational instruction decoder: slices the IR into register indices,
// function/type/stop fields and a type-selected sign-extended immediate.
module inst_decoder
  import cpu_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  inst_function,
  output logic [4:0]  rs1,
  output logic [4:0]  rd,
  output logic [4:0]  rs2,
  output logic [1:0]  inst_type,
  output logic        stop_bit,
  output logic [31:0] imm_ext
);

  logic [IMM_I_W-1:0] imm_i;
  logic [IMM_J_W-1:0] imm_j;

  assign inst_function = ir[FUNC_MSB:FUNC_LSB];
  assign rs1           = ir[RS1_MSB:RS1_LSB];
  assign rd            = ir[RD_MSB:RD_LSB];
  assign rs2           = ir[RS2_MSB:RS2_LSB];
  assign inst_type     = ir[TYPE_MSB:TYPE_LSB];
  assign stop_bit      = ir[STOP_BIT];
  assign imm_i         = ir[IMM_I_MSB:IMM_I_LSB];
  assign imm_j         = ir[IMM_J_MSB:IMM_J_LSB];

  // Reserved type carries no immediate, same as R-type.
  always_comb begin
    imm_ext = 32'h0;
    case (inst_type_e'(inst_type))
      TYPE_I:  imm_ext = {{(32-IMM_I_W){imm_i[IMM_I_W-1]}}, imm_i};
      TYPE_J:  imm_ext = {{(32-IMM_J_W){imm_j[IMM_J_W-1]}}, imm_j};
      default: imm_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Multi-cycle fetch stage: owns the PC, fetches into the IR and holds it for the
// control unit until retirement. Optional reserved-type trap: ILLEGAL_TRAP_EN.
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int unsigned RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [31:0]       imem_rdata,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic [4:0]        inst_function,
  output logic [4:0]        rs1,
  output logic [4:0]        rd,
  output logic [4:0]        rs2,
  output logic [1:0]        inst_type,
  output logic              stop_bit,
  output logic [31:0]       imm_ext,
  output logic              illegal
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic              imem_req_q, imem_req_d;
  logic              ir_valid_q, ir_valid_d;
`ifdef ILLEGAL_TRAP_EN
  logic              illegal_q, illegal_d;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    imem_req_d = imem_req_q;
    ir_valid_d = ir_valid_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d  = illegal_q;
`endif
    case (state_q)
      ST_IDLE: begin
        state_d    = ST_FETCH;
        imem_req_d = 1'b1;
      end
      ST_FETCH: begin
        if (imem_valid) begin
          ir_d       = imem_rdata;
          imem_req_d = 1'b0;
`ifdef ILLEGAL_TRAP_EN
          if (inst_type_e'(imem_rdata[TYPE_MSB:TYPE_LSB]) == TYPE_RSVD) begin
            state_d   = ST_TRAP;
            illegal_d = 1'b1;
          end else begin
            state_d    = ST_HOLD;
            ir_valid_d = 1'b1;
          end
`else
          state_d    = ST_HOLD;
          ir_valid_d = 1'b1;
`endif
        end
      end
      ST_HOLD: begin
        if (ir_ready) begin
          pc_d       = pc_load ? pc_next : pc_q + ADDR_W'(1);
          state_d    = ST_FETCH;
          imem_req_d = 1'b1;
          ir_valid_d = 1'b0;
        end
      end
      // Trap is terminal until reset; PC stays at the faulting address.
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= ADDR_W'(RESET_PC);
      ir_q       <= 32'h0;
      imem_req_q <= 1'b0;
      ir_valid_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      imem_req_q <= imem_req_d;
      ir_valid_q <= ir_valid_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q  <= illegal_d;
`endif
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign ir_valid  = ir_valid_q;
  assign pc        = pc_q;
  assign pc_plus1  = pc_q + ADDR_W'(1);
`ifdef ILLEGAL_TRAP_EN
  assign illegal   = illegal_q;
`else
  assign illegal   = 1'b0;
`endif

  inst_decoder u_dec (
    .ir            (ir_q),
    .inst_function (inst_function),
    .rs1           (rs1),
    .rd            (rd),
    .rs2           (rs2),
    .inst_type     (inst_type),
    .stop_bit      (stop_bit),
    .imm_ext       (imm_ext)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: reset, fetch latency, wait states,
// PC sequencing/redirect/wrap, immediates, HOLD stability and reserved type.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic        pc_load;
  logic [31:0] pc_next;
  logic [31:0] pc;
  logic [31:0] pc_plus1;
  logic [4:0]  inst_function;
  logic [4:0]  rs1;
  logic [4:0]  rd;
  logic [4:0]  rs2;
  logic [1:0]  inst_type;
  logic        stop_bit;
  logic [31:0] imm_ext;
  logic        illegal;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  inst_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .pc_load       (pc_load),
    .pc_next       (pc_next),
    .pc            (pc),
    .pc_plus1      (pc_plus1),
    .inst_function (inst_function),
    .rs1           (rs1),
    .rd            (rd),
    .rs2           (rs2),
    .inst_type     (inst_type),
    .stop_bit      (stop_bit),
    .imm_ext       (imm_ext),
    .illegal       (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    ir_ready   = 1'b0;
    pc_load    = 1'b0;
    pc_next    = 32'h0;
    tick();
    tick();

    chk("rst_req",      {31'h0, imem_req}, 32'h0);
    chk("rst_irvalid",  {31'h0, ir_valid}, 32'h0);
    chk("rst_pc",       pc, 32'h0);
    chk("rst_pcp1",     pc_plus1, 32'h1);
    chk("rst_type",     {30'h0, inst_type}, 32'h0);
    chk("rst_func",     {27'h0, inst_function}, 32'h0);
    chk("rst_imm",      imm_ext, 32'h0);
    chk("rst_illegal",  {31'h0, illegal}, 32'h0);

    // Release reset: IDLE one cycle, then FETCH.
    rst_n = 1'b1;
    tick();
    chk("f0_req",  {31'h0, imem_req}, 32'h1);
    chk("f0_addr", imem_addr, 32'h0);

    // Zero-wait fetch of an I-type word with function 1.
    imem_valid = 1'b1;
    imem_rdata = 32'h0800_0002;
    tick();
    imem_valid = 1'b0;
    chk("zw_irvalid", {31'h0, ir_valid}, 32'h1);
    chk("zw_func",    {27'h0, inst_function}, 32'h1);
    chk("zw_type",    {30'h0, inst_type}, 32'h1);
    chk("zw_imm",     imm_ext, 32'h0);
    chk("zw_req",     {31'h0, imem_req}, 32'h0);

    // HOLD with ir_ready low for 10 cycles while memory and pc_load toggle.
    pc_load = 1'b1;
    pc_next = 32'h1234;
    for (int i = 0; i < 10; i++) begin
      imem_valid = i[0];
      imem_rdata = 32'hFFFF_FFFF;
      tick();
    end
    imem_valid = 1'b0;
    pc_load    = 1'b0;
    chk("hold_irvalid", {31'h0, ir_valid}, 32'h1);
    chk("hold_req",     {31'h0, imem_req}, 32'h0);
    chk("hold_func",    {27'h0, inst_function}, 32'h1);
    chk("hold_type",    {30'h0, inst_type}, 32'h1);
    chk("hold_pc",      pc, 32'h0);

    // Retire with redirect to 0x40.
    ir_ready = 1'b1;
    pc_load  = 1'b1;
    pc_next  = 32'h40;
    tick();
    ir_ready = 1'b0;
    pc_load  = 1'b0;
    chk("redir_addr",    imem_addr, 32'h40);
    chk("redir_req",     {31'h0, imem_req}, 32'h1);
    chk("redir_irvalid", {31'h0, ir_valid}, 32'h0);

    // Three wait cycles: request held, valid arrives in FETCH cycle 4.
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk($sformatf("wait%0d_req", c),  {31'h0, imem_req}, 32'h1);
      chk($sformatf("wait%0d_addr", c), imem_addr, 32'h40);
      chk($sformatf("wait%0d_irv", c),  {31'h0, ir_valid}, 32'h0);
    end
    imem_valid = 1'b1;
    imem_rdata = 32'h07FF_FFFC;   // J-type, IR[26:3] all ones
    tick();
    imem_valid = 1'b0;
    chk("j_irvalid", {31'h0, ir_valid}, 32'h1);
    chk("j_type",    {30'h0, inst_type}, 32'h2);
    chk("j_imm",     imm_ext, 32'hFFFF_FFFF);
    chk("j_rs1",     {27'h0, rs1}, 32'h1F);
    chk("j_pc",      pc, 32'h40);
    chk("j_pcp1",    pc_plus1, 32'h41);

    // Sequential advance 0x40 -> 0x41.
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    chk("seq_addr", imem_addr, 32'h41);

    imem_valid = 1'b1;
    imem_rdata = 32'h0001_0003;   // I-type, IR[16:3]=0x2000, stop bit set
    tick();
    imem_valid = 1'b0;
    chk("i_imm",  imm_ext, 32'hFFFF_E000);
    chk("i_type", {30'h0, inst_type}, 32'h1);
    chk("i_stop", {31'h0, stop_bit}, 32'h1);
    chk("i_rs2",  {27'h0, rs2}, 32'h10);
    chk("i_pc",   pc, 32'h41);

    // Redirect to all-ones, then check wrap of pc_plus1 and of the PC.
    ir_ready = 1'b1;
    pc_load  = 1'b1;
    pc_next  = 32'hFFFF_FFFF;
    tick();
    ir_ready = 1'b0;
    pc_load  = 1'b0;
    chk("max_addr", imem_addr, 32'hFFFF_FFFF);
    imem_valid = 1'b1;
    imem_rdata = 32'h1234_5670;   // R-type, function 2
    tick();
    imem_valid = 1'b0;
    chk("r_imm",   imm_ext, 32'h0);
    chk("r_func",  {27'h0, inst_function}, 32'h2);
    chk("r_type",  {30'h0, inst_type}, 32'h0);
    chk("wrap_p1", pc_plus1, 32'h0);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    chk("wrap_addr", imem_addr, 32'h0);

    // pc_load without ir_ready in FETCH is ignored.
    pc_load = 1'b1;
    pc_next = 32'h99;
    tick();
    pc_load = 1'b0;
    chk("ign_load_addr", imem_addr, 32'h0);
    chk("ign_load_req",  {31'h0, imem_req}, 32'h1);

    // Reserved inst_type capture.
    imem_valid = 1'b1;
    imem_rdata = 32'h0000_0006;
    tick();
    imem_valid = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    chk("trap_illegal", {31'h0, illegal}, 32'h1);
    chk("trap_irvalid", {31'h0, ir_valid}, 32'h0);
    chk("trap_req",     {31'h0, imem_req}, 32'h0);
    ir_ready   = 1'b1;
    pc_load    = 1'b1;
    pc_next    = 32'h55;
    imem_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    ir_ready   = 1'b0;
    pc_load    = 1'b0;
    imem_valid = 1'b0;
    chk("trap_stay_ill", {31'h0, illegal}, 32'h1);
    chk("trap_stay_irv", {31'h0, ir_valid}, 32'h0);
    chk("trap_pc",       pc, 32'h0);
`else
    chk("rsvd_irvalid", {31'h0, ir_valid}, 32'h1);
    chk("rsvd_illegal", {31'h0, illegal}, 32'h0);
    chk("rsvd_type",    {30'h0, inst_type}, 32'h3);
    chk("rsvd_imm",     imm_ext, 32'h0);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    chk("rsvd_next", imem_addr, 32'h1);
`endif

    // Reset mid-fetch; a late imem_valid while in IDLE is dropped.
    rst_n = 1'b0;
    tick();
    chk("rst2_req",     {31'h0, imem_req}, 32'h0);
    chk("rst2_irvalid", {31'h0, ir_valid}, 32'h0);
    chk("rst2_illegal", {31'h0, illegal}, 32'h0);
    chk("rst2_pc",      pc, 32'h0);
    rst_n      = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'h0800_0002;
    tick();
    imem_valid = 1'b0;
    chk("late_irvalid", {31'h0, ir_valid}, 32'h0);
    chk("late_req",     {31'h0, imem_req}, 32'h1);
    chk("late_func",    {27'h0, inst_function}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Multi-cycle fetch stage directly upstream of `ControlUnit`. It owns the PC, fetches one 32-bit instruction word per instruction over a request/valid handshake to instruction memory, and holds it in an instruction register (IR). It presents the decoded fields (`inst_type`, `inst_function`, `stop_bit`, register indices, extended immediate) to the control unit until the control unit signals retirement. The PC then advances sequentially or to a redirect target.

## Interface
Parameters:
- `ADDR_W`, 32: PC / instruction-address width (word addressed)
- `RESET_PC`, 0: PC value after reset

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `imem_req`  out  1  fetch request, held until `imem_valid`
- `imem_addr`  out  ADDR_W  fetch address (= PC)
- `imem_valid`  in  1  `imem_rdata` valid this cycle
- `imem_rdata`  in  32  instruction word
- `ir_valid`  out  1  IR holds an instruction for the control unit
- `ir_ready`  in  1  control unit retires the current instruction
- `pc_load`  in  1  with `ir_ready`: next PC = `pc_next`
- `pc_next`  in  ADDR_W  redirect target (jump/call/return)
- `pc`  out  ADDR_W  address of the instruction in IR
- `pc_plus1`  out  ADDR_W  `pc + 1` (return address for calls)
- `inst_function`  out  5  IR[31:27]
- `rs1`, `rd`, `rs2`  out  5 each  IR[26:22], IR[21:17], IR[16:12]
- `inst_type`  out  2  IR[2:1]: 00 R, 01 I, 10 J, 11 reserved
- `stop_bit`  out  1  IR[0]
- `imm_ext`  out  32  I-type: sign-extended IR[16:3]; J-type: sign-extended IR[26:3]; R-type: 0
- `illegal`  out  1  sticky reserved-type trap flag

## Operation
- States: IDLE, FETCH, HOLD, TRAP (TRAP exists only with the macro).
- IDLE: entered on reset; moves to FETCH unconditionally on the next cycle.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. On a cycle with `imem_valid`=1: IR <= `imem_rdata`, go to HOLD. `imem_valid` in any other state is ignored.
- HOLD: `ir_valid`=1; IR and all decoded outputs remain stable. When `ir_ready`=1: `pc` <= `pc_load` ? `pc_next` : `pc`+1, then go to FETCH.
- `pc_load` without `ir_ready`, or outside HOLD, is ignored.
- PC arithmetic is modulo 2^ADDR_W: `pc`=all-ones plus 1 wraps to 0, and the same applies to `pc_plus1`.
- Decode is purely combinational from IR. Field slices overlap by design; consumers select by `inst_type`.

## Timing
- Reset values: state IDLE, `pc`=RESET_PC, IR=0, `imem_req`=0, `ir_valid`=0, `illegal`=0. Outputs decode IR=0 (type R, function 0, `imm_ext`=0).
- Zero-wait memory (`imem_valid` in the first FETCH cycle): IR is visible with `ir_valid` on the next cycle.
- With `ir_ready` in the first HOLD cycle, the minimum throughput is 2 cycles per instruction. Each memory wait cycle adds one cycle.
- After `ir_ready`, the new `pc` and `imem_addr` are presented in the next cycle.
- `rst_n` low mid-fetch or mid-hold: the in-flight fetch is abandoned. A late `imem_valid` while in IDLE is dropped.

## Configuration
- `ILLEGAL_TRAP_EN` defined: capturing an IR with `inst_type`=11 enters TRAP instead of HOLD. In TRAP, `ir_valid`=0 and `imem_req`=0, `illegal`=1 (sticky), and the PC is frozen at the faulting address. Only reset exits TRAP.
- `ILLEGAL_TRAP_EN` undefined: type 11 is passed to the control unit like any other type, and `illegal` is tied to 0.

## Structure
- Shared package `cpu_pkg` holds:
  - the inst-type encoding constants (R/I/J/reserved)
  - the IR field bit positions
  - the fetch state enum
  - `RESET_PC` default
- Sub-module `inst_decoder` (combinational): IR in, field slices and `imm_ext` out. It is reused by the verification scoreboard.

## Test plan
- Reset then zero-wait memory, `imem_rdata`=0x0800_0002 at addr 0 → next cycle `ir_valid`=1, `inst_function`=1, `inst_type`=01, `imm_ext`=0.
- 3 wait cycles before `imem_valid` → `imem_req`/`imem_addr` held stable, `ir_valid` rises on cycle 5 after FETCH entry.
- `ir_ready` with `pc_load`=1, `pc_next`=0x40 → next `imem_addr`=0x40. Without `pc_load` from `pc`=0x40 → 0x41. From `pc`=0xFFFF_FFFF → 0.
- J-type IR[26:3]=0xFFFFFF → `imm_ext`=0xFFFF_FFFF. I-type IR[16:3]=0x2000 → `imm_ext`=0xFFFF_E000.
- `ir_ready` held low for 10 cycles in HOLD, `imem_valid` toggled → IR/outputs unchanged, no new `imem_req`.
- `inst_type`=11 captured: with `ILLEGAL_TRAP_EN` → `illegal`=1, `ir_valid`=0 until `rst_n` low. Without → `ir_valid`=1, `illegal`=0.
